// File: rtl/dma_pkg.sv
// Shared types and defaults for the single-channel DMA between the buffered IO device and memory.
package dma_pkg;

    localparam int unsigned DMA_AW = 8;
    localparam int unsigned DMA_DW = 32;
    localparam int unsigned DMA_LW = 5;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitReq,
        StXferIn,
        StXferOut,
        StDrain,
        StDone
    } dma_state_e;

endpackage

// File: rtl/dma_io_channel_if.sv
// Command, device-handshake and memory signals of the DMA channel; master is the DMA side.
interface dma_io_channel_if
    import dma_pkg::*;
#(
    parameter int unsigned AW = DMA_AW,
    parameter int unsigned DW = DMA_DW,
    parameter int unsigned LW = DMA_LW
) ();

    logic          start;
    logic          dir;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          abort;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] xfer_count;

    logic          gpio;
    logic          io_cs;
    logic          io_write;
    logic [DW-1:0] io_wdata;
    logic [DW-1:0] io_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  start, dir, base_addr, length, abort, gpio, io_rdata, mem_rdata,
        output busy, done, aborted, xfer_count, io_cs, io_write, io_wdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, dir, base_addr, length, abort, gpio, io_rdata, mem_rdata,
        input  busy, done, aborted, xfer_count, io_cs, io_write, io_wdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dma_addr_counter.sv
// Issue, memory-index and completed-word counters for one transfer, cleared on each accepted start.
module dma_addr_counter
    import dma_pkg::*;
#(
    parameter int unsigned LW = DMA_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic [LW-1:0] i_length,
    input  logic          i_inc_issue,
    input  logic          i_inc_idx,
    input  logic          i_inc_count,
    output logic [LW-1:0] o_idx,
    output logic [LW-1:0] o_count,
    output logic          o_issue_tc
);

    logic [LW-1:0] r_issued;
    logic [LW-1:0] r_idx;
    logic [LW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued <= '0;
            r_idx    <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_issued <= '0;
            r_idx    <= '0;
            r_count  <= '0;
        end else begin
            if (i_inc_issue) r_issued <= r_issued + LW'(1);
            if (i_inc_idx)   r_idx    <= r_idx + LW'(1);
            if (i_inc_count) r_count  <= r_count + LW'(1);
        end
    end

    assign o_idx      = r_idx;
    assign o_count    = r_count;
    assign o_issue_tc = (r_issued == i_length);

endmodule

// File: rtl/dma_io_channel.sv
// Single-channel DMA: device->memory on gpio request, memory->device on start; one word per cycle.
module dma_io_channel
    import dma_pkg::*;
#(
    parameter int unsigned AW = DMA_AW,
    parameter int unsigned DW = DMA_DW,
    parameter int unsigned LW = DMA_LW
) (
    input logic              clk,
    input logic              rst_n,
    dma_io_channel_if.master bus
);

    dma_state_e    r_state;
    logic [AW-1:0] r_base;
    logic [LW-1:0] r_length;
    logic          r_abort_seen;
    logic          r_in_cap;
    logic          r_out_cap;

    logic          w_in_issue;
    logic          w_out_issue;
    logic          w_abort_live;
    logic          w_issue_tc;
    logic [LW-1:0] w_idx;
    logic [LW-1:0] w_count;
    logic [AW-1:0] w_addr;

    // A new read is issued only while words remain, the device still has data and no abort.
    assign w_in_issue   = (r_state == StXferIn) && !w_issue_tc && bus.gpio && !bus.abort;
    assign w_out_issue  = (r_state == StXferOut) && !w_issue_tc && !bus.abort;
    assign w_abort_live = bus.abort &&
                          (r_state == StWaitReq || r_state == StXferIn || r_state == StXferOut);
    assign w_addr       = r_base + AW'(w_idx);

    dma_addr_counter #(
        .LW (LW)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     ((r_state == StIdle) && bus.start),
        .i_length    (r_length),
        .i_inc_issue (w_in_issue || w_out_issue),
        .i_inc_idx   (w_out_issue || r_in_cap),
        .i_inc_count (r_in_cap || r_out_cap),
        .o_idx       (w_idx),
        .o_count     (w_count),
        .o_issue_tc  (w_issue_tc)
    );

    assign bus.xfer_count = w_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_base        <= '0;
            r_length      <= '0;
            r_abort_seen  <= 1'b0;
            r_in_cap      <= 1'b0;
            r_out_cap     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.aborted   <= 1'b0;
            bus.io_cs     <= 1'b0;
            bus.io_write  <= 1'b0;
            bus.io_wdata  <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            // Read data from either side is valid the cycle after its strobe; forward it then.
            r_in_cap     <= bus.io_cs && !bus.io_write;
            r_out_cap    <= bus.mem_en && !bus.mem_we;
            bus.io_cs    <= w_in_issue || r_out_cap;
            bus.io_write <= r_out_cap;
            bus.mem_en   <= w_out_issue || r_in_cap;
            bus.mem_we   <= r_in_cap;
            if (r_out_cap) bus.io_wdata <= bus.mem_rdata;
            if (r_in_cap) bus.mem_wdata <= bus.io_rdata;
            if (w_out_issue || r_in_cap) bus.mem_addr <= w_addr;

            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
            if (w_abort_live) r_abort_seen <= 1'b1;

            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_base       <= bus.base_addr;
                        r_length     <= bus.length;
                        r_abort_seen <= 1'b0;
                        bus.busy     <= 1'b1;
                        if (bus.length == '0)       r_state <= StDone;
                        else if (bus.dir == DIR_OUT) r_state <= StXferOut;
                        else                         r_state <= StWaitReq;
                    end
                end
                StWaitReq: begin
                    if (bus.abort)     r_state <= StDone;
                    else if (bus.gpio) r_state <= StXferIn;
                end
                StXferIn: begin
                    if (!w_in_issue) r_state <= StDrain;
                end
                StXferOut: begin
                    if (!w_out_issue) r_state <= StDrain;
                end
                StDrain: begin
                    r_state <= StDone;
                end
                StDone: begin
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    bus.aborted <= r_abort_seen;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_io_channel.sv
// Directed bench for dma_io_channel with a word memory model and a buffered-device model.
module tb_dma_io_channel;
    import dma_pkg::*;

    localparam int unsigned AW = DMA_AW;
    localparam int unsigned DW = DMA_DW;
    localparam int unsigned LW = DMA_LW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_io_channel_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

    dma_io_channel #(
        .AW (AW),
        .DW (DW),
        .LW (LW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: registered read, one cycle latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];

    // Device buffer: gpio means a word is still pending beyond the one being read right now.
    logic [DW-1:0] dev_buf [0:31];
    int dev_first = 0;
    int dev_count = 0;
    int dev_pops  = 0;
    always @(posedge clk) begin
        if (bus.io_cs && !bus.io_write) begin
            bus.io_rdata <= dev_buf[5'(dev_pops - dev_first)];
            dev_pops     <= dev_pops + 1;
        end
    end
    assign bus.gpio = (dev_count - (dev_pops - dev_first)) > ((bus.io_cs && !bus.io_write) ? 1 : 0);

    // Bus monitor
    int unsigned   mw_cyc [$];
    logic [AW-1:0] mw_addr [$];
    logic [DW-1:0] mw_data [$];
    int unsigned   iw_cyc [$];
    logic [DW-1:0] iw_data [$];
    int unsigned   n_io_cs  = 0;
    int unsigned   n_mem_en = 0;
    always @(negedge clk) begin
        if (bus.io_cs) n_io_cs <= n_io_cs + 1;
        if (bus.mem_en) n_mem_en <= n_mem_en + 1;
        if (bus.mem_en && bus.mem_we) begin
            mw_cyc.push_back(cyc);
            mw_addr.push_back(bus.mem_addr);
            mw_data.push_back(bus.mem_wdata);
        end
        if (bus.io_cs && bus.io_write) begin
            iw_cyc.push_back(cyc);
            iw_data.push_back(bus.io_wdata);
        end
    end

    int unsigned s_cyc, s_mw, s_iw, s_cs, s_en;
    int unsigned d_cyc;
    logic        d_seen, d_abort, d_busy;
    logic [LW-1:0] d_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic dev_load(input int n, input logic [DW-1:0] first_word);
        dev_first = dev_pops;
        dev_count = n;
        for (int i = 0; i < n; i++) dev_buf[i] = first_word + DW'(i);
    endtask

    task automatic start_xfer(input logic d, input logic [AW-1:0] base, input logic [LW-1:0] len);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dir       = d;
        bus.base_addr = base;
        bus.length    = len;
        s_cyc = cyc;
        s_mw  = mw_cyc.size();
        s_iw  = iw_cyc.size();
        s_cs  = n_io_cs;
        s_en  = n_mem_en;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        d_seen = 1'b0;
        d_cyc  = 0;
        for (int i = 0; i < budget && !d_seen; i++) begin
            if (bus.done) begin
                d_seen  = 1'b1;
                d_cyc   = cyc;
                d_abort = bus.aborted;
                d_count = bus.xfer_count;
                d_busy  = bus.busy;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(d_seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_mem_writes(input string tag, input int n, input logic [AW-1:0] addr0,
                                    input logic [DW-1:0] data0, input int unsigned cyc0);
        check({tag, "_nwrites"}, 32'(mw_cyc.size() - s_mw), 32'(n));
        if (mw_cyc.size() - s_mw == n) begin
            for (int i = 0; i < n; i++) begin
                check({tag, "_waddr"}, 32'(mw_addr[s_mw + i]), 32'(addr0 + AW'(i)));
                check({tag, "_wdata"}, mw_data[s_mw + i], data0 + DW'(i));
                check({tag, "_wcyc"}, mw_cyc[s_mw + i] - s_cyc, cyc0 + i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.dir       = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.abort     = 1'b0;
        mem[8'hFE] = 32'd1;
        mem[8'hFF] = 32'd2;
        mem[8'h00] = 32'd3;
        mem[8'h20] = 32'h55;
        mem[8'h21] = 32'h66;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({bus.busy, bus.done, bus.aborted}), 32'd0);
        check("reset_bus", 32'({bus.io_cs, bus.io_write, bus.mem_en, bus.mem_we}), 32'd0);
        check("reset_count", 32'(bus.xfer_count), 32'd0);
        rst_n = 1'b1;

        // IN, 3 words all available: writes at +5..+7, done at +8
        dev_load(3, 32'hA);
        start_xfer(DIR_IN, 8'h10, 5'd3);
        check("in3_busy", 32'(bus.busy), 32'd1);
        wait_done("in3", 40);
        check_mem_writes("in3", 3, 8'h10, 32'hA, 5);
        check("in3_done_cyc", d_cyc - s_cyc, 32'd8);
        check("in3_count", 32'(d_count), 32'd3);
        check("in3_aborted", 32'(d_abort), 32'd0);
        check("in3_busy_at_done", 32'(d_busy), 32'd0);
        check("in3_reads", n_io_cs - s_cs, 32'd3);

        // IN, length 5 but device empties after 2 words
        dev_load(2, 32'h11);
        start_xfer(DIR_IN, 8'h40, 5'd5);
        wait_done("in_gpio", 40);
        check_mem_writes("in_gpio", 2, 8'h40, 32'h11, 5);
        check("in_gpio_done_cyc", d_cyc - s_cyc, 32'd7);
        check("in_gpio_count", 32'(d_count), 32'd2);
        check("in_gpio_aborted", 32'(d_abort), 32'd0);
        check("in_gpio_reads", n_io_cs - s_cs, 32'd2);

        // OUT with address wrap 0xFE,0xFF,0x00
        start_xfer(DIR_OUT, 8'hFE, 5'd3);
        wait_done("out_wrap", 40);
        check("out_wrap_nwrites", iw_cyc.size() - s_iw, 32'd3);
        if (iw_cyc.size() - s_iw == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("out_wrap_data", iw_data[s_iw + i], 32'(i + 1));
                check("out_wrap_cyc", iw_cyc[s_iw + i] - s_cyc, 32'(4 + i));
            end
        end
        check("out_wrap_done_cyc", d_cyc - s_cyc, 32'd7);
        check("out_wrap_count", 32'(d_count), 32'd3);
        check("out_wrap_mem_en", n_mem_en - s_en, 32'd3);

        // Zero length
        start_xfer(DIR_IN, 8'h00, 5'd0);
        wait_done("len0", 10);
        check("len0_done_cyc", d_cyc - s_cyc, 32'd2);
        check("len0_count", 32'(d_count), 32'd0);
        check("len0_io_cs", n_io_cs - s_cs, 32'd0);
        check("len0_mem_en", n_mem_en - s_en, 32'd0);

        // OUT aborted after one issue, plus a start pulse while busy
        start_xfer(DIR_OUT, 8'h20, 5'd3);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.start     = 1'b1;
        bus.dir       = DIR_IN;
        bus.length    = 5'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("abort", 20);
        check("abort_done_cyc", d_cyc - s_cyc, 32'd5);
        check("abort_aborted", 32'(d_abort), 32'd1);
        check("abort_count", 32'(d_count), 32'd1);
        check("abort_nwrites", iw_cyc.size() - s_iw, 32'd1);
        if (iw_cyc.size() - s_iw == 1) check("abort_data", iw_data[s_iw], 32'h55);
        repeat (4) @(negedge clk);
        check("abort_ignored_start", 32'(bus.busy), 32'd0);
        check("abort_count_held", 32'(bus.xfer_count), 32'd1);
        check("abort_mem_en", n_mem_en - s_en, 32'd1);

        // Reset in the middle of an IN transfer
        dev_load(5, 32'h100);
        start_xfer(DIR_IN, 8'h80, 5'd5);
        repeat (5) @(negedge clk);
        check("rst_pre_mem_en", 32'({bus.mem_en, bus.mem_we, bus.io_cs}), 32'b111);
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", 32'({bus.busy, bus.done, bus.aborted}), 32'd0);
        check("rst_bus", 32'({bus.io_cs, bus.io_write, bus.mem_en, bus.mem_we}), 32'd0);
        check("rst_count", 32'(bus.xfer_count), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dev_load(1, 32'h5A);
        start_xfer(DIR_IN, 8'h03, 5'd1);
        wait_done("post_rst", 20);
        check_mem_writes("post_rst", 1, 8'h03, 32'h5A, 5);
        check("post_rst_done_cyc", d_cyc - s_cyc, 32'd6);
        check("post_rst_count", 32'(d_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_io_channel.md
Name: dma_io_channel

Overview:
- Single-channel DMA engine sitting directly upstream/downstream of the buffered IO device.
- Drives the device's CS/IOWrite/Data handshake and moves words between the device buffer and a synchronous word-addressed memory.
- Direction IN (device -> memory) is triggered by the device's GPIO request line.
- Direction OUT (memory -> device) starts immediately on the start command.

Parameters:
- AW, 8, memory word-address width
- DW, 32, data word width (matches device Data bus)
- LW, 5, transfer-length width (max 31 words, equal to device buffer depth)

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle command pulse, sampled only in IDLE
- dir  input  1  0 = IN (device -> memory), 1 = OUT (memory -> device); latched on start
- base_addr  input  AW  first memory word address; latched on start
- length  input  LW  number of words; latched on start
- abort  input  1  stop transfer after in-flight word
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- aborted  output  1  valid with done: 1 if ended by abort
- xfer_count  output  LW  words completed; held after done until next start
- gpio  input  1  device request line (words pending)
- io_cs  output  1  device chip select
- io_write  output  1  device IOWrite (1 = write into device)
- io_wdata  output  DW  data toward device; top level tristates it onto Data when io_write=1
- io_rdata  input  DW  Data bus as seen from device; valid 1 cycle after an io_cs read cycle
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory word address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data; valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset: all outputs 0, FSM IDLE, idx = 0.
- Reset mid-transfer drops everything immediately; no done pulse is generated.
- FSM states: IDLE, WAIT_REQ, XFER_IN, XFER_OUT, DRAIN, DONE.
- IDLE:
  - start=1 latches dir/base_addr/length, clears xfer_count and idx, sets busy.
  - length=0 -> DONE (done next cycle, xfer_count=0).
  - dir=0 -> WAIT_REQ; dir=1 -> XFER_OUT.
  - start is ignored in every other state.
- WAIT_REQ: idle outputs; gpio=1 -> XFER_IN; abort -> DONE with aborted=1.
- XFER_IN (one word per cycle, pipelined):
  - Issue cycle: io_cs=1, io_write=0.
  - Next cycle: capture io_rdata; mem_en=1, mem_we=1, mem_addr=base_addr+idx, mem_wdata=captured word; idx and xfer_count increment.
  - Issue stops when issued == length, gpio=0, or abort=1 -> DRAIN.
  - The word already issued is always written (no loss).
- XFER_OUT (one word per cycle, pipelined):
  - Issue cycle: mem_en=1, mem_we=0, mem_addr=base_addr+idx.
  - Next cycle: io_cs=1, io_write=1, io_wdata=mem_rdata; xfer_count increments.
  - Issue stops at length or abort -> DRAIN.
- DRAIN: completes the single in-flight word, then -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle; aborted=1 if an abort was seen; -> IDLE.
- Address arithmetic: base_addr+idx is modulo 2^AW; wrap is silent and allowed.
- gpio falling simultaneously with the length limit is treated as normal completion (aborted=0).
- abort and normal completion in the same cycle: aborted=1.
- io_cs and mem_en are never both asserted with write semantics toward the same side in one cycle; at most one outstanding word per direction.

Decomposition:
- Shared package dma_pkg: FSM state enum, DIR_IN/DIR_OUT constants, default AW/DW/LW.
- One natural sub-module: dma_addr_counter (idx/xfer_count register with load, increment, terminal-count flag).
- FSM and data pipeline register stay in the top module.

Test Plan:
- IN, base=0x10, length=3, device holds 0xA,0xB,0xC with gpio=1: mem writes 0xA@0x10, 0xB@0x11, 0xC@0x12 on consecutive cycles; done one cycle after last write; xfer_count=3, aborted=0.
- IN, length=5, gpio drops after 2 issues: exactly 2 words written, done, xfer_count=2, aborted=0.
- OUT, base=0xFE, length=3, memory 0xFE=1, 0xFF=2, 0x00=3: io_write cycles carry 1,2,3 (address wraps to 0x00); xfer_count=3.
- length=0 start: done pulses on the 2nd cycle after start, no io_cs or mem_en activity.
- abort during OUT after 1 issue: in-flight word delivered, done with aborted=1, xfer_count=1; start pulses during busy are ignored.
- rst_n asserted mid-XFER_IN: all outputs 0 asynchronously; after release, FSM is IDLE and accepts a new start.
